// File: rtl/aes_dec_sequencer.sv
// Iterative AES-128 decryptor: one shared inverse-round datapath, one round per clock.
// Optional AES_DEC_ABORT_EN adds an abort input that drops the block in flight.
module aes_dec_sequencer #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  input  logic [1407:0] round_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic [3:0]    round
`ifdef AES_DEC_ABORT_EN
  ,
  input  logic          abort
`endif
);

  localparam logic [3:0] LAST_KEY = 4'(NR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_n;
  logic [3:0]   rc, rc_n;
  logic [127:0] data_q, data_n;
  logic [127:0] out_q, out_n;

  logic [127:0] keys [11];
  logic [127:0] key_sel;
  logic [127:0] isr, isb, ark, imc, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then GF(2^8) inverse as x^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] s;
    logic [7:0] r;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    s = y;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  for (genvar k = 0; k < 11; k++) begin : g_keys
    assign keys[k] = round_keys[1407 - 128*k -: 128];
  end

  always_comb begin
    key_sel = keys[0];
    for (int k = 1; k < 11; k++) begin
      if (rc == 4'(k)) key_sel = keys[k];
    end
  end

  // The last round (rc = 0) skips InvMixColumns.
  assign isr       = inv_shift_rows(data_q);
  assign isb       = inv_sub_bytes(isr);
  assign ark       = isb ^ key_sel;
  assign imc       = inv_mix_columns(ark);
  assign round_out = (rc == 4'd0) ? ark : imc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rc     <= LAST_KEY;
      data_q <= '0;
      out_q  <= '0;
    end else begin
      state  <= state_n;
      rc     <= rc_n;
      data_q <= data_n;
      out_q  <= out_n;
    end
  end

  always_comb begin
    state_n = state;
    rc_n    = rc;
    data_n  = data_q;
    out_n   = out_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = RUN;
          data_n  = in_data ^ keys[10];
          rc_n    = LAST_KEY - 4'd1;
        end
      end
      RUN: begin
        data_n = round_out;
        if (rc == 4'd0) begin
          out_n   = round_out;
          state_n = DONE;
        end else begin
          rc_n = rc - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          rc_n    = LAST_KEY;
        end
      end
      default: begin
        state_n = IDLE;
        rc_n    = LAST_KEY;
      end
    endcase
`ifdef AES_DEC_ABORT_EN
    if (abort && state != IDLE) begin
      state_n = IDLE;
      rc_n    = LAST_KEY;
      data_n  = data_q;
      out_n   = out_q;
    end
`endif
  end

  always_comb begin
    case (state)
      RUN:     round = rc;
      DONE:    round = 4'd0;
      default: round = LAST_KEY;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Self-checking bench for aes_dec_sequencer using FIPS-197 vectors and a queue scoreboard.
// Define AES_DEC_ABORT_EN to also exercise the abort port.
module tb_aes_dec_sequencer;

  localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [1407:0] KEYS_A = {
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};

  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [1407:0] KEYS_B = {
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [1407:0] round_keys;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;
  logic [3:0]    round;
`ifdef AES_DEC_ABORT_EN
  logic          abort;
`endif

  logic [127:0] exp_q [$];
  logic [127:0] exp_data;
  int checks = 0;
  int passed = 0;

  aes_dec_sequencer #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .round_keys (round_keys),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .round      (round)
`ifdef AES_DEC_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (round !== 4'd10) $display("[TB] FAIL reset_round: got %0d expected 10", round); else passed++;
    checks++; if (out_data !== 128'h0) $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready); else passed++;
  endtask

  // FIPS vector with latency, round sequence, busy rejection and output backpressure.
  task automatic test_fips_backpressure;
    round_keys = KEYS_A;
    out_ready  = 1'b0;
    in_data    = CT_A;
    in_valid   = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL fips_in_ready: got %b expected 1", in_ready); else passed++;
    exp_q.push_back(PT_A);
    tick;
    in_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      checks++; if (round !== 4'(9 - j)) $display("[TB] FAIL fips_round_%0d: got %0d expected %0d", j, round, 9 - j); else passed++;
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL fips_early_valid_%0d: got %b expected 0", j, out_valid); else passed++;
      if (j == 2) begin
        in_valid = 1'b1;
        in_data  = '0;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL busy_in_ready: got %b expected 0", in_ready); else passed++;
      end else begin
        in_valid = 1'b0;
      end
      tick;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL fips_latency: out_valid got %b expected 1", out_valid); else passed++;
    checks++; if (round !== 4'd0) $display("[TB] FAIL fips_done_round: got %0d expected 0", round); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL fips_done_busy: got %b expected 1", busy); else passed++;
    exp_data = exp_q.pop_front();
    checks++; if (out_data !== exp_data) $display("[TB] FAIL fips_data: got %h expected %h", out_data, exp_data); else passed++;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid_%0d: got %b expected 1", k, out_valid); else passed++;
      checks++; if (out_data !== PT_A) $display("[TB] FAIL bp_data_%0d: got %h expected %h", k, out_data, PT_A); else passed++;
      checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready_%0d: got %b expected 0", k, in_ready); else passed++;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL bp_release_busy: got %b expected 0", busy); else passed++;
    checks++; if (round !== 4'd10) $display("[TB] FAIL bp_release_round: got %0d expected 10", round); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_data !== PT_A) $display("[TB] FAIL idle_hold_data: got %h expected %h", out_data, PT_A); else passed++;
  endtask

  task automatic test_reset_midrun;
    bit got;
    int lat;
    round_keys = KEYS_A;
    out_ready  = 1'b0;
    in_data    = CT_A;
    in_valid   = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b expected 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (round !== 4'd10) $display("[TB] FAIL midrst_round: got %0d expected 10", round); else passed++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL midrst_in_ready_held: got %b expected 0", in_ready); else passed++;
    checks++; if (out_data !== 128'h0) $display("[TB] FAIL midrst_out_data: got %h expected 0", out_data); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); else passed++;
    exp_q.push_back(PT_A);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick;
      lat = k + 2;
      if (out_valid) begin
        got = 1'b1;
        lat = k + 1;
      end
    end
    checks++; if (got !== 1'b1) $display("[TB] FAIL midrst_timeout: out_valid got 0 expected 1 within 20 cycles"); else passed++;
    checks++; if (lat != 10) $display("[TB] FAIL midrst_latency: got %0d expected 10", lat); else passed++;
    if (got) begin
      exp_data = exp_q.pop_front();
      checks++; if (out_data !== exp_data) $display("[TB] FAIL midrst_data: got %h expected %h", out_data, exp_data); else passed++;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_second_vector;
    bit got;
    round_keys = KEYS_B;
    in_data    = CT_B;
    in_valid   = 1'b1;
    exp_q.push_back(PT_B);
    tick;
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick;
      if (out_valid) got = 1'b1;
    end
    checks++; if (got !== 1'b1) $display("[TB] FAIL vecb_timeout: out_valid got 0 expected 1 within 20 cycles"); else passed++;
    if (got) begin
      exp_data = exp_q.pop_front();
      checks++; if (out_data !== exp_data) $display("[TB] FAIL vecb_data: got %h expected %h", out_data, exp_data); else passed++;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    round_keys = KEYS_A;
  endtask

  // in_valid stays high throughout, so the second accept lands at the first legal edge.
  task automatic test_back_to_back;
    int acc;
    int pulses;
    int first_cyc;
    int second_cyc;
    acc        = 0;
    pulses     = 0;
    first_cyc  = 0;
    second_cyc = 0;
    round_keys = KEYS_A;
    out_ready  = 1'b1;
    in_data    = CT_A;
    in_valid   = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(PT_A);
        acc++;
      end
      tick;
      if (acc == 2) in_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) first_cyc = cyc;
        if (pulses == 2) second_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL b2b_unexpected_valid: got out_valid 1 expected no pending block");
        end else begin
          exp_data = exp_q.pop_front();
          checks++; if (out_data !== exp_data) $display("[TB] FAIL b2b_data_%0d: got %h expected %h", pulses, out_data, exp_data); else passed++;
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (pulses != 2) $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses); else passed++;
    checks++; if (first_cyc != 11) $display("[TB] FAIL b2b_first_latency: got %0d expected 11", first_cyc); else passed++;
    checks++; if (second_cyc - first_cyc != 12) $display("[TB] FAIL b2b_spacing: got %0d expected 12", second_cyc - first_cyc); else passed++;
    checks++; if (exp_q.size() != 0) $display("[TB] FAIL b2b_leftover: got %0d expected 0", exp_q.size()); else passed++;
  endtask

`ifdef AES_DEC_ABORT_EN
  task automatic test_abort;
    int seen;
    bit got;
    round_keys = KEYS_A;
    out_ready  = 1'b0;
    in_data    = CT_A;
    in_valid   = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passed++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (round !== 4'd10) $display("[TB] FAIL abort_round: got %0d expected 10", round); else passed++;
    checks++; if (out_data !== PT_A) $display("[TB] FAIL abort_keep_data: got %h expected %h", out_data, PT_A); else passed++;
    seen = 0;
    repeat (12) begin
      tick;
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) $display("[TB] FAIL abort_no_pulse: got %0d cycles expected 0", seen); else passed++;
    abort    = 1'b1;
    in_valid = 1'b1;
    exp_q.push_back(PT_A);
    tick;
    abort    = 1'b0;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL abort_idle_accept: busy got %b expected 1", busy); else passed++;
    checks++; if (round !== 4'd9) $display("[TB] FAIL abort_idle_round: got %0d expected 9", round); else passed++;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick;
      if (out_valid) got = 1'b1;
    end
    checks++; if (got !== 1'b1) $display("[TB] FAIL abort_idle_timeout: out_valid got 0 expected 1 within 20 cycles"); else passed++;
    if (got) begin
      exp_data = exp_q.pop_front();
      checks++; if (out_data !== exp_data) $display("[TB] FAIL abort_idle_data: got %h expected %h", out_data, exp_data); else passed++;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    round_keys = KEYS_A;
    out_ready  = 1'b0;
`ifdef AES_DEC_ABORT_EN
    abort      = 1'b0;
`endif
    test_reset;
    test_fips_backpressure;
    test_reset_midrun;
    test_second_vector;
    test_back_to_back;
`ifdef AES_DEC_ABORT_EN
    test_abort;
`else
    $display("[TB] abort port not built into this configuration");
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
